// File: rtl/snake_state_map.sv
// snake_state_map
//
// Holds the live snake game state and answers per-cell queries from the
// frame scanner on a 16x16 grid. The per-cell flags feed image_generator.
// The snake moves one cell for each step pulse from the game tick source.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   nrst         asynchronous reset, active-high (despite the name)
//   step         single-cycle pulse: advance the snake one cell
//   dir_valid    dir_req carries a new direction request this cycle
//   dir_req[1:0] 00 right (+x), 01 left (-x), 10 up (-y), 11 down (+y)
//   apple_x/y    current apple cell, from the apple generator
//   x/y          query cell, from image_generator
//   snakeBody    query cell holds a non-head segment
//   snakeHead    query cell holds the head
//   apple        query cell is the apple cell
//   border       query cell lies on the outer ring (x or y is 0 or 15)
//   GameOver     sticky collision flag; this is also the exposed phase state
//   apple_eaten  one-cycle pulse after a step whose new head hit the apple
//   length[5:0]  current segment count
//
// Handshake: step and dir_valid have no ready. Each one is consumed in the
// cycle where it is high. A request is either applied or dropped. Drops
// happen for a reversal, and for any request while the game is over.

module snake_state_map #(
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 8,
    parameter int START_Y  = 8
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       step,
    input  logic       dir_valid,
    input  logic [1:0] dir_req,
    input  logic [3:0] apple_x,
    input  logic [3:0] apple_y,
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic       snakeBody,
    output logic       snakeHead,
    output logic       apple,
    output logic       border,
    output logic       GameOver,
    output logic       apple_eaten,
    output logic [5:0] length
);

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    // Two-state game phase. GameOver is a direct decode of this register.
    typedef enum logic {
        PH_PLAY = 1'b0,
        PH_OVER = 1'b1
    } phase_t;

    localparam logic [5:0] MAX_LEN_L  = 6'(MAX_LEN);
    localparam logic [5:0] INIT_LEN_L = 6'(INIT_LEN);

    // Segment storage. Index 0 is the head. Entries at or beyond the
    // current length hold stale positions and are masked out everywhere.
    logic [3:0] seg_x [MAX_LEN];
    logic [3:0] seg_y [MAX_LEN];

    phase_t     phase_q, phase_d;
    dir_t       dir_q, dir_d, eff_dir;
    logic [5:0] len_q, len_d;
    logic       eaten_q, eaten_d;
    logic       advance;

    logic       reversal;
    logic       accept_dir;
    logic [3:0] nh_x, nh_y;
    logic       eat, grow, wall, self_hit;
    logic [5:0] self_lim;

    // ------------------------------------------------------------------
    // Direction request filtering
    // ------------------------------------------------------------------
    // Opposite directions share bit 1 and differ only in bit 0.
    assign reversal   = ((dir_req ^ dir_q) == 2'b01);
    assign accept_dir = dir_valid && (phase_q == PH_PLAY) && !reversal;
    // A direction accepted in the same cycle as a step steers that step.
    assign eff_dir    = accept_dir ? dir_t'(dir_req) : dir_q;

    // ------------------------------------------------------------------
    // Candidate head and collision evaluation
    // ------------------------------------------------------------------
    always_comb begin
        nh_x = seg_x[0];
        nh_y = seg_y[0];
        case (eff_dir)
            DIR_RIGHT: nh_x = seg_x[0] + 4'd1;
            DIR_LEFT:  nh_x = seg_x[0] - 4'd1;
            DIR_UP:    nh_y = seg_y[0] - 4'd1;
            DIR_DOWN:  nh_y = seg_y[0] + 4'd1;
            default:   nh_x = seg_x[0];
        endcase
    end

    assign eat  = (nh_x == apple_x) && (nh_y == apple_y);
    assign grow = eat && (len_q < MAX_LEN_L);
    assign wall = (nh_x == 4'd0) || (nh_x == 4'd15) ||
                  (nh_y == 4'd0) || (nh_y == 4'd15);

    // The tail cell is vacated by a non-growing step. A move into it is
    // therefore legal unless the snake grows on this step. Segments
    // 0 .. self_lim-1 count as obstacles.
    assign self_lim = len_q - 6'd1 + {5'd0, grow};

    always_comb begin
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((6'(i) < self_lim) && (seg_x[i] == nh_x) && (seg_y[i] == nh_y)) begin
                self_hit = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        phase_d = phase_q;
        dir_d   = dir_q;
        len_d   = len_q;
        eaten_d = 1'b0;
        advance = 1'b0;

        if (accept_dir) begin
            dir_d = eff_dir;
        end

        if (step && (phase_q == PH_PLAY)) begin
            if (wall || self_hit) begin
                // A fatal step freezes the snake exactly as it was.
                // This includes a direction requested in the same cycle.
                phase_d = PH_OVER;
                dir_d   = dir_q;
            end else begin
                advance = 1'b1;
                len_d   = len_q + {5'd0, grow};
                eaten_d = eat;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            phase_q <= PH_PLAY;
            dir_q   <= DIR_RIGHT;
            len_q   <= INIT_LEN_L;
            eaten_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            dir_q   <= dir_d;
            len_q   <= len_d;
            eaten_q <= eaten_d;
        end
    end

    // The body lies horizontally, trailing to the left of the start cell.
    // Entries beyond INIT_LEN get the same formula. They are harmless
    // because the length masks them.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= 4'(START_X - i);
                seg_y[i] <= 4'(START_Y);
            end
        end else if (advance) begin
            // The whole array shifts. The old tail falls into an unused
            // slot unless the length grows to cover it.
            for (int i = MAX_LEN - 1; i > 0; i--) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
            end
            seg_x[0] <= nh_x;
            seg_y[0] <= nh_y;
        end
    end

    // ------------------------------------------------------------------
    // Cell queries: combinational, valid every cycle
    // ------------------------------------------------------------------
    assign snakeHead = (x == seg_x[0]) && (y == seg_y[0]);

    always_comb begin
        snakeBody = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((6'(i) < len_q) && (seg_x[i] == x) && (seg_y[i] == y)) begin
                snakeBody = 1'b1;
            end
        end
    end

    assign apple  = (x == apple_x) && (y == apple_y);
    assign border = (x == 4'd0) || (x == 4'd15) || (y == 4'd0) || (y == 4'd15);

    assign GameOver    = (phase_q == PH_OVER);
    assign apple_eaten = eaten_q;
    assign length      = len_q;

endmodule

// File: doc/snake_state_map.md
Name: snake_state_map

Overview:
- Holds the live snake game state: segment positions, length, direction, apple-eaten flag and game-over flag.
- Answers per-cell object queries from the frame scanner on the 16x16 grid.
- Sits directly upstream of image_generator:
  - drives its snakeBody, snakeHead, apple, border and GameOver inputs;
  - consumes its x, y scan coordinates.
- Advances the snake one cell per step pulse from the game tick source.

Parameters:
- MAX_LEN, 32, maximum number of stored segments (2..63).
- INIT_LEN, 3, segment count after reset (2..MAX_LEN).
- START_X, 8, head x after reset.
- START_Y, 8, head y after reset.

Ports:
- clk  in  1  system clock, all state on rising edge
- nrst  in  1  reset, asynchronous, active-high
- step  in  1  single-cycle pulse: advance snake one cell
- dir_valid  in  1  dir_req is a new direction request this cycle
- dir_req  in  2  00 right (+x), 01 left (-x), 10 up (-y), 11 down (+y)
- apple_x  in  4  current apple column (from apple generator)
- apple_y  in  4  current apple row
- x  in  4  query column (from image_generator)
- y  in  4  query row
- snakeBody  out  1  query cell holds a non-head segment
- snakeHead  out  1  query cell holds the head
- apple  out  1  query cell == (apple_x, apple_y)
- border  out  1  query x or y is 0 or 15
- GameOver  out  1  sticky collision flag
- apple_eaten  out  1  one-cycle pulse, head reached apple
- length  out  6  current segment count

Behaviour:
- Reset (nrst=1, asynchronous):
  - seg[i] = (START_X - i, START_Y) for i < INIT_LEN;
  - length = INIT_LEN, direction = right;
  - GameOver = 0, apple_eaten = 0.
  - Unused seg entries are don't-care and are never compared.
- Query outputs are combinational from x, y and current state: zero latency, valid every cycle including during GameOver.
  - snakeHead = (x,y) == seg[0].
  - snakeBody = any seg[i] with 1 <= i < length equals (x,y).
  - apple and border are pure compares.
  - Multiple flags may be 1 simultaneously.
- Direction register:
  - On dir_valid, accept dir_req unless it is the 180-degree reverse of the current direction; a reversal is ignored.
  - If step and dir_valid occur in the same cycle, the accepted new direction applies to that step.
- Step (step=1 and GameOver=0):
  - nh = seg[0] + unit vector of the effective direction; 4-bit arithmetic.
  - eat = (nh == (apple_x, apple_y)).
  - grow = eat and length < MAX_LEN.
  - wall = nh.x in {0,15} or nh.y in {0,15}.
  - self = nh equals seg[i] for 0 <= i < length-1, or for i = length-1 when grow. The tail cell is legal unless growing.
  - If wall or self: GameOver <= 1 next edge; segments, length and direction unchanged; apple_eaten stays 0.
  - Otherwise:
    - seg[i+1] <= seg[i] for all i;
    - seg[0] <= nh;
    - length <= length + grow;
    - apple_eaten <= eat, a pulse for exactly one cycle after the step edge.
  - At MAX_LEN, eat still pulses apple_eaten but length saturates and the tail moves.
- step while GameOver = 1: ignored. dir_valid while GameOver = 1: ignored.
- GameOver is cleared only by reset.
- step asserted on consecutive cycles: each cycle is a full step. No internal rate limiting.
- Reset mid-step: reset wins and all state returns to reset values asynchronously.
- Head never reaches 0 or 15 without GameOver, so 4-bit wrap of nh cannot produce a live segment.

Test Plan:
1. Reset with defaults, query (8,8), (7,8), (6,8), (5,8) -> snakeHead=1 / snakeBody=1 / snakeBody=1 / all 0; length=3, GameOver=0; query (0,4) -> border=1.
2. Three step pulses, no dir_valid -> head (11,8), segments (10,8),(9,8); query (8,8) -> snakeBody=0; length=3.
3. dir_valid with dir_req=01 (reverse) then step -> head (9,8), reversal ignored. Then dir_valid=1, dir_req=10 together with step -> head (9,7).
4. Apple at (9,8), step from reset -> apple_eaten=1 for exactly one cycle; length=4; tail still at (6,8). With length=MAX_LEN and the same eat -> length stays MAX_LEN.
5. From reset, 6 steps right -> head (14,8). 7th step -> GameOver=1, head still (14,8). Further step and dir_valid -> no state change; query outputs still valid.
6. Grow to length 5, then drive right, down, left, up with one step each -> GameOver=1 on the up step. Repeat at length 4 -> the head enters the vacating tail cell and GameOver=0.
